// File: rtl/sccb_target.sv
// SCCB responder: oversampled SIO_C/SIO_D, start/stop detection, ID match, ACK,
// and a register-port handshake. Optional macro: SCCB_ADDR_INC_EN (auto-increment reg_addr).
module sccb_target #(
    parameter int ADDR16      = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  dev_id,
    input  logic        sccb_clk,
    input  logic        sccb_data_in,
    output logic        sccb_data_out,
    output logic        sccb_data_en,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_wr,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ID     = 4'd1,
        S_SUB_H  = 4'd2,
        S_SUB_L  = 4'd3,
        S_WDATA  = 4'd4,
        S_RDATA  = 4'd5,
        S_ACK    = 4'd6,
        S_MACK   = 4'd7,
        S_IGNORE = 4'd8
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    state_t      r_state, w_state_nxt;
    state_t      r_ack_next, w_ack_next_nxt;
    logic [3:0]  r_bitcnt, w_bitcnt_nxt;
    logic [6:0]  r_shift, w_shift_nxt;
    logic        r_phase, w_phase_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_en, w_en_nxt;
    logic        r_out, w_out_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;
    logic        r_wr, w_wr_nxt;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;

`ifdef SCCB_ADDR_INC_EN
    function automatic logic [15:0] f_addr_inc(input logic [15:0] a);
        if (ADDR16 != 0)
            return a + 16'd1;
        else
            return {8'h00, a[7:0] + 8'd1};
    endfunction
`endif

    // Bus idles high, so the synchronizers reset to 1 to avoid a false start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], sccb_clk};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sccb_data_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift, w_sda};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ack_next <= S_IDLE;
            r_bitcnt   <= 4'd0;
            r_shift    <= 7'd0;
            r_phase    <= 1'b0;
            r_busy     <= 1'b0;
            r_en       <= 1'b0;
            r_out      <= 1'b0;
            r_addr     <= 16'd0;
            r_wdata    <= 8'd0;
            r_wr       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ack_next <= w_ack_next_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_shift    <= w_shift_nxt;
            r_phase    <= w_phase_nxt;
            r_busy     <= w_busy_nxt;
            r_en       <= w_en_nxt;
            r_out      <= w_out_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wr       <= w_wr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ack_next_nxt = r_ack_next;
        w_bitcnt_nxt   = r_bitcnt;
        w_shift_nxt    = r_shift;
        w_phase_nxt    = r_phase;
        w_busy_nxt     = r_busy;
        w_en_nxt       = r_en;
        w_out_nxt      = r_out;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_wr_nxt       = 1'b0;
`ifdef SCCB_ADDR_INC_EN
        if (r_wr)
            w_addr_nxt = f_addr_inc(r_addr);
`endif
        if (w_start) begin
            w_state_nxt  = S_ID;
            w_bitcnt_nxt = 4'd0;
            w_phase_nxt  = 1'b0;
            w_en_nxt     = 1'b0;
            w_out_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_bitcnt_nxt = 4'd0;
            w_phase_nxt  = 1'b0;
            w_busy_nxt   = 1'b0;
            w_en_nxt     = 1'b0;
            w_out_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_ID, S_SUB_H, S_SUB_L, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_byte[6:0];
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            w_bitcnt_nxt = 4'd0;
                            w_phase_nxt  = 1'b0;
                            w_state_nxt  = S_ACK;
                            case (r_state)
                                S_ID: begin
                                    if (w_byte[7:1] == dev_id) begin
                                        w_busy_nxt     = 1'b1;
                                        w_ack_next_nxt = w_byte[0] ? S_RDATA :
                                                         ((ADDR16 != 0) ? S_SUB_H : S_SUB_L);
                                    end else begin
                                        w_state_nxt = S_IGNORE;
                                    end
                                end
                                S_SUB_H: begin
                                    w_addr_nxt[15:8] = w_byte;
                                    w_ack_next_nxt   = S_SUB_L;
                                end
                                S_SUB_L: begin
                                    w_addr_nxt[7:0] = w_byte;
                                    if (ADDR16 == 0)
                                        w_addr_nxt[15:8] = 8'h00;
                                    w_ack_next_nxt = S_WDATA;
                                end
                                default: begin
                                    w_wdata_nxt    = w_byte;
                                    w_wr_nxt       = 1'b1;
                                    w_ack_next_nxt = S_WDATA;
                                end
                            endcase
                        end
                    end
                end
                // Phase 0 waits for the fall that starts the ACK slot, phase 1 for the one ending it.
                S_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_en_nxt    = 1'b1;
                            w_out_nxt   = 1'b0;
                            w_phase_nxt = 1'b1;
                        end else begin
                            w_en_nxt     = 1'b0;
                            w_out_nxt    = 1'b0;
                            w_phase_nxt  = 1'b0;
                            w_bitcnt_nxt = 4'd0;
                            w_state_nxt  = r_ack_next;
                            if (r_ack_next == S_RDATA) begin
                                w_en_nxt    = 1'b1;
                                w_out_nxt   = reg_rdata[7];
                                w_shift_nxt = reg_rdata[6:0];
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_en_nxt    = 1'b0;
                            w_out_nxt   = 1'b0;
                            w_phase_nxt = 1'b0;
                            w_state_nxt = S_MACK;
                        end else begin
                            w_out_nxt   = r_shift[6];
                            w_shift_nxt = {r_shift[5:0], 1'b0};
                        end
                    end
                end
                S_MACK: begin
                    if (w_scl_rise && !r_phase) begin
                        w_phase_nxt = 1'b1;
`ifdef SCCB_ADDR_INC_EN
                        w_addr_nxt = f_addr_inc(r_addr);
`endif
                        if (w_sda)
                            w_state_nxt = S_IGNORE;
                    end else if (w_scl_fall && r_phase) begin
                        w_phase_nxt  = 1'b0;
                        w_bitcnt_nxt = 4'd0;
                        w_state_nxt  = S_RDATA;
                        w_en_nxt     = 1'b1;
                        w_out_nxt    = reg_rdata[7];
                        w_shift_nxt  = reg_rdata[6:0];
                    end
                end
                S_IGNORE: begin
                    w_en_nxt  = 1'b0;
                    w_out_nxt = 1'b0;
                end
                S_IDLE: begin
                    w_en_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign sccb_data_out = r_out;
    assign sccb_data_en  = r_en;
    assign reg_addr      = r_addr;
    assign reg_wdata     = r_wdata;
    assign reg_wr        = r_wr;
    assign busy          = r_busy;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: bit-banged SCCB host, open-drain bus model,
// write scoreboard keyed on {addr, data}; follows SCCB_ADDR_INC_EN when defined.
module tb_sccb_target;

  localparam int Q = 4;  // quarter of an SCL period, in clk cycles

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  dev_id;
  logic        m_scl;
  logic        m_sda;
  logic        sda_bus;
  logic        sccb_data_out;
  logic        sccb_data_en;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_wr;
  logic [7:0]  reg_rdata;
  logic        busy;
  logic [3:0]  dbg_state;

  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int en_cnt = 0;
  int busy_cnt = 0;
  int wr_long = 0;
  logic wr_prev = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Open-drain bus: either side can pull SIO_D low.
  assign sda_bus   = m_sda & ~(sccb_data_en & ~sccb_data_out);
  // Register file model: a fixed pattern of the low address byte.
  assign reg_rdata = reg_addr[7:0] ^ 8'h5C;

  sccb_target #(.ADDR16(1), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .dev_id        (dev_id),
    .sccb_clk      (m_scl),
    .sccb_data_in  (sda_bus),
    .sccb_data_out (sccb_data_out),
    .sccb_data_en  (sccb_data_en),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_wr        (reg_wr),
    .reg_rdata     (reg_rdata),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reg_wr) obs_q.push_back({reg_addr, reg_wdata});
    if (reg_wr && wr_prev) wr_long++;
    wr_prev = reg_wr;
    if (sccb_data_en) en_cnt++;
    if (busy) busy_cnt++;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(tag, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b, output logic s, output logic e);
    m_sda = b;    wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    s = sda_bus;
    e = sccb_data_en;
    wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s, e;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s, e);
    send_bit(1'b1, s, e);
    acked = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d, output logic en_ack);
    logic s, e;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s, e);
      d[i] = s;
    end
    send_bit(nack, s, e);
    en_ack = e;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic a;
    logic s, e;
    logic [7:0] d;
    logic [7:0] bytes4 [4];
    logic [15:0] exp_addr;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; dev_id = 7'h3C;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);
    check("rst_en", sccb_data_en, 0);
    check("rst_out", sccb_data_out, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wr", reg_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);

    // Write 78 30 08 82: every byte ACKed, one write at 3008.
    bytes4[0] = 8'h78; bytes4[1] = 8'h30; bytes4[2] = 8'h08; bytes4[3] = 8'h82;
    exp_q.push_back({16'h3008, 8'h82});
    bus_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes4[i], a);
      check($sformatf("t1_ack%0d", i), a, 1);
    end
    check("t1_busy", busy, 1);
    bus_stop();
    check("t1_busy_stop", busy, 0);
    check("t1_state", dbg_state, 0);
    check("t1_en", sccb_data_en, 0);
    check_writes("t1_wr");

    // ID mismatch: no ACK, no drive, never busy.
    en_cnt = 0; busy_cnt = 0;
    bus_start();
    write_byte(8'h7A, a);
    check("t2_ack_id", a, 0);
    write_byte(8'h30, a);
    check("t2_ack_b1", a, 0);
    bus_stop();
    check("t2_en_cnt", en_cnt, 0);
    check("t2_busy_cnt", busy_cnt, 0);
    check_writes("t2_wr");

    // Set address 300A, then read one byte with NA.
    bus_start();
    write_byte(8'h78, a); write_byte(8'h30, a); write_byte(8'h0A, a);
    check("t3_ack_sub", a, 1);
    bus_stop();
    bus_start();
    write_byte(8'h79, a);
    check("t3_ack_rd", a, 1);
    read_byte(1'b1, d, e);
    check("t3_rdata", d, 8'h56);
    check("t3_na_en", e, 0);
    check("t3_busy", busy, 1);
    bus_stop();
    check("t3_busy_stop", busy, 0);
`ifdef SCCB_ADDR_INC_EN
    exp_addr = 16'h300B;
`else
    exp_addr = 16'h300A;
`endif
    check("t3_addr", reg_addr, exp_addr);
    check_writes("t3_wr");

    // Two-byte read from 300A: master ACKs the first, NAs the second.
    bus_start();
    write_byte(8'h78, a); write_byte(8'h30, a); write_byte(8'h0A, a);
    bus_stop();
    bus_start();
    write_byte(8'h79, a);
    read_byte(1'b0, d, e);
    check("t3b_rdata0", d, 8'h56);
    read_byte(1'b1, d, e);
`ifdef SCCB_ADDR_INC_EN
    check("t3b_rdata1", d, 8'h57);
`else
    check("t3b_rdata1", d, 8'h56);
`endif
    bus_stop();

    // Write 78 FF FF 11 22: second byte lands at 0000 only with auto-increment.
    exp_q.push_back({16'hFFFF, 8'h11});
`ifdef SCCB_ADDR_INC_EN
    exp_q.push_back({16'h0000, 8'h22});
    exp_addr = 16'h0001;
`else
    exp_q.push_back({16'hFFFF, 8'h22});
    exp_addr = 16'hFFFF;
`endif
    bus_start();
    write_byte(8'h78, a); write_byte(8'hFF, a); write_byte(8'hFF, a);
    write_byte(8'h11, a);
    check("t4_ack_d0", a, 1);
    write_byte(8'h22, a);
    check("t4_ack_d1", a, 1);
    bus_stop();
    check("t4_addr", reg_addr, exp_addr);
    check_writes("t4_wr");

    // Stop after 4 data bits: partial byte dropped.
    bus_start();
    write_byte(8'h78, a); write_byte(8'h30, a); write_byte(8'h08, a);
    send_bit(1'b1, s, e); send_bit(1'b0, s, e); send_bit(1'b1, s, e); send_bit(1'b0, s, e);
    bus_stop();
    check("t5_state", dbg_state, 0);
    check("t5_en", sccb_data_en, 0);
    check_writes("t5_wr");

    // Reset pulse while the ID ACK is being driven.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(bytes4[0][i], s, e);
    check("t5b_ack_drv", sccb_data_en, 1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("t5b_en_rst", sccb_data_en, 0);
    check("t5b_state_rst", dbg_state, 0);
    check("t5b_busy_rst", busy, 0);
    en_cnt = 0;
    send_bit(1'b1, s, e);
    write_byte(8'h30, a); write_byte(8'h08, a); write_byte(8'h99, a);
    bus_stop();
    check("t5b_en_cnt", en_cnt, 0);
    check_writes("t5b_wr");

    // Normal transfer after the reset.
    exp_q.push_back({16'h1234, 8'h56});
    bus_start();
    write_byte(8'h78, a);
    check("t5c_ack_id", a, 1);
    write_byte(8'h12, a); write_byte(8'h34, a); write_byte(8'h56, a);
    check("t5c_ack_d", a, 1);
    bus_stop();
    check_writes("t5c_wr");

    check("wr_pulse_len", wr_long, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
